// File: rtl/key_cmd_ctrl_if.sv
// key_cmd_ctrl_if: command handshake between the key sequencer (master) and the player (slave).
interface key_cmd_ctrl_if #(
  parameter int TRK_W = 2
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_code;
  logic [TRK_W-1:0] cmd_track;

  modport master (output cmd_valid, output cmd_code, output cmd_track, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_code, input cmd_track, output cmd_ready);
endinterface

// File: rtl/key_cmd_ctrl.sv
// key_cmd_ctrl: latches debounced key pulses, grants them by fixed priority and issues player
// commands over valid/ready. Define KEY_CMD_AUTO_NEXT_EN to add the song_end auto-advance input.
module key_cmd_ctrl #(
  parameter int NUM_TRACKS = 4,
  parameter int TRK_W      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            key_p,
`ifdef KEY_CMD_AUTO_NEXT_EN
  input  logic                  song_end,
`endif
  key_cmd_ctrl_if.master        cmd,
  output logic                  playing,
  output logic [TRK_W-1:0]      track,
  output logic                  busy
);

`ifdef KEY_CMD_AUTO_NEXT_EN
  localparam int PEND_W = 5;
`else
  localparam int PEND_W = 4;
`endif

  typedef enum logic {IDLE, ISSUE} state_t;
  typedef enum logic [1:0] {
    CMD_PLAY  = 2'd0,
    CMD_PAUSE = 2'd1,
    CMD_TRACK = 2'd2,
    CMD_STOP  = 2'd3
  } cmd_t;

  state_t            state, state_nxt;
  logic [PEND_W-1:0] pend, pend_in, pend_clr;
  logic [PEND_W-1:0] grant_q, grant_nxt;
  cmd_t              code_q, code_nxt;
  logic [TRK_W-1:0]  cmd_track_q, cmd_track_nxt;
  logic [TRK_W-1:0]  next_track_q, next_track_nxt;
  logic [TRK_W-1:0]  trk_inc, trk_dec;
  logic              next_play_q, next_play_nxt;
  logic              load, accept;

`ifdef KEY_CMD_AUTO_NEXT_EN
  assign pend_in = {song_end, key_p};
`else
  assign pend_in = key_p;
`endif

  // Explicit wrap: NUM_TRACKS need not be a power of two.
  assign trk_inc = (track == TRK_W'(NUM_TRACKS - 1)) ? '0 : track + TRK_W'(1);
  assign trk_dec = (track == '0) ? TRK_W'(NUM_TRACKS - 1) : track - TRK_W'(1);

  assign accept = (state == ISSUE) && cmd.cmd_ready;

  always_comb begin
    state_nxt      = state;
    grant_nxt      = '0;
    code_nxt       = code_q;
    cmd_track_nxt  = track;
    next_track_nxt = track;
    next_play_nxt  = playing;
    load           = 1'b0;
    pend_clr       = '0;
    case (state)
      IDLE: begin
        if (pend[0]) begin
          grant_nxt[0]  = 1'b1;
          load          = 1'b1;
          code_nxt      = playing ? CMD_PAUSE : CMD_PLAY;
          next_play_nxt = ~playing;
        end else if (pend[1]) begin
          grant_nxt[1]   = 1'b1;
          load           = 1'b1;
          code_nxt       = CMD_TRACK;
          next_track_nxt = trk_inc;
          cmd_track_nxt  = trk_inc;
        end else if (pend[2]) begin
          grant_nxt[2]   = 1'b1;
          load           = 1'b1;
          code_nxt       = CMD_TRACK;
          next_track_nxt = trk_dec;
          cmd_track_nxt  = trk_dec;
        end else if (pend[3]) begin
          grant_nxt[3]  = 1'b1;
          load          = 1'b1;
          code_nxt      = CMD_STOP;
          next_play_nxt = 1'b0;
        end
`ifdef KEY_CMD_AUTO_NEXT_EN
        // End of song only advances while playing; otherwise it is silently discarded.
        else if (pend[4]) begin
          if (playing) begin
            grant_nxt[4]   = 1'b1;
            load           = 1'b1;
            code_nxt       = CMD_TRACK;
            next_track_nxt = trk_inc;
            cmd_track_nxt  = trk_inc;
          end else begin
            pend_clr[4] = 1'b1;
          end
        end
`endif
        if (load) state_nxt = ISSUE;
      end
      ISSUE: begin
        if (cmd.cmd_ready) begin
          state_nxt = IDLE;
          pend_clr  = grant_q;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // New pulses are OR-ed in after the clear so a re-press on the accept edge stays queued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend <= '0;
    else     pend <= (pend & ~pend_clr) | pend_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_q       <= CMD_PLAY;
      cmd_track_q  <= '0;
      next_track_q <= '0;
      next_play_q  <= 1'b0;
      grant_q      <= '0;
      playing      <= 1'b0;
      track        <= '0;
    end else begin
      if (load) begin
        code_q       <= code_nxt;
        cmd_track_q  <= cmd_track_nxt;
        next_track_q <= next_track_nxt;
        next_play_q  <= next_play_nxt;
        grant_q      <= grant_nxt;
      end
      if (accept) begin
        playing <= next_play_q;
        track   <= next_track_q;
      end
    end
  end

  assign cmd.cmd_valid = (state == ISSUE);
  assign cmd.cmd_code  = code_q;
  assign cmd.cmd_track = cmd_track_q;
  assign busy          = (state == ISSUE);

endmodule

// File: doc/key_cmd_ctrl.md
Name: key_cmd_ctrl

Overview:
- Command sequencer between the per-button debouncers and the tone/music player.
- Each debouncer emits a one-cycle press pulse. This block does three things:
  - latches every pulse so none is lost;
  - arbitrates between buttons with fixed priority;
  - turns the granted button into a player command, delivered over a valid/ready handshake.
- Owns the authoritative play/pause state and the current track index.

Parameters:
- NUM_TRACKS, 4, number of tracks; track index wraps modulo NUM_TRACKS (legal range 2..2^TRK_W).
- TRK_W, 2, width of the track index.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- key_p  in  4  one-cycle press pulses from the debouncers. Bit 0 = play/pause, bit 1 = next, bit 2 = prev, bit 3 = stop.
- cmd_valid  out  1  command available to the player.
- cmd_ready  in  1  player accepts the command.
- cmd_code  out  2  command code: 0 PLAY, 1 PAUSE, 2 TRACK, 3 STOP.
- cmd_track  out  TRK_W  track index carried with the command.
- playing  out  1  current play state.
- track  out  TRK_W  current track.
- busy  out  1  high while a command is outstanding (FSM in ISSUE).

Behaviour:
- Reset (asynchronous, immediate):
  - every output goes to 0: cmd_valid, cmd_code, cmd_track, playing, track, busy;
  - pending register cleared; FSM returns to IDLE;
  - a handshake in flight is abandoned, and cmd_valid drops without waiting for a clock edge.
- Pending register pend[3:0]:
  - pend[i] is set on the clock edge after key_p[i]=1;
  - pend[i] is cleared on the accept edge (cmd_valid & cmd_ready) of a command granted to i;
  - if set and clear hit the same edge, set wins, so a re-press during accept stays queued;
  - repeat pulses of an already-pending key merge into one.
- FSM states: IDLE, ISSUE.
- IDLE:
  - if pend != 0, grant the lowest set index;
  - compute the command and next state, register them into cmd_code, cmd_track and a shadow next-state;
  - move to ISSUE; cmd_valid=1 on the next cycle.
- ISSUE:
  - hold cmd_valid, cmd_code and cmd_track stable until cmd_ready=1;
  - on the accept edge: commit the shadow state to playing/track, clear pend[grant], drop cmd_valid, return to IDLE;
  - no new grant is made until back in IDLE, giving at least one idle cycle between commands.
- Latency: with key_p pulsed at edge N, pend is set at N+1 and cmd_valid=1 at N+2, provided the FSM is idle.
- Command mapping (all evaluated at grant time from the current state):
  - key0: if playing=1, cmd PAUSE and next playing=0; else cmd PLAY and next playing=1. cmd_track = track.
  - key1: next track = (track == NUM_TRACKS-1) ? 0 : track+1. cmd TRACK with cmd_track = next track. playing unchanged.
  - key2: next track = (track == 0) ? NUM_TRACKS-1 : track-1. cmd TRACK. playing unchanged.
  - key3: cmd STOP, next playing=0, track unchanged. Issued even if already stopped.
- Simultaneous pulses are served one at a time in index order, e.g. key1+key2 gives next, then prev, and the net track is unchanged.
- cmd_ready while cmd_valid=0 is ignored.
- cmd_ready held high permanently is legal; throughput is one command every 2 cycles.
- All arithmetic is TRK_W bits wide. Track wrap is explicit, never natural overflow, because NUM_TRACKS need not be a power of two.

Optional Feature:
- Macro: KEY_CMD_AUTO_NEXT_EN.
- Defined:
  - adds input port song_end (1 bit), a one-cycle pulse from the player at the end of a track;
  - latched as pend[4], lowest priority;
  - when granted with playing=1: behaves exactly as key1 (cmd TRACK, wrap), playing stays 1;
  - when granted with playing=0: pend[4] is cleared in IDLE with no command issued and no ISSUE state.
- Undefined: song_end port absent, pend is 4 bits, behaviour exactly as above.

Test Plan:
- Reset mid-operation: pulse key0 and let the FSM enter ISSUE with cmd_ready=0, then assert rst -> cmd_valid=0 the same cycle; after release: pend=0, playing=0, track=0, no command issued.
- Play/pause toggle: from reset, cmd_ready=1, pulse key0 at edge N -> cmd_valid at N+2 with cmd_code=0; playing=1 after accept. Pulse key0 again -> cmd_code=1, playing=0.
- Wrap-around: NUM_TRACKS=3; pulse key1 three times -> cmd_track sequence 1, 2, 0. Then pulse key2 -> cmd_track=2.
- Simultaneous and backpressure: key_p=4'b1110 in one cycle, cmd_ready held 0 for 5 cycles -> cmd_valid and fields stable throughout. Order of commands is TRACK 1, TRACK 0, STOP; final track=0, playing=0.
- Re-press during accept: key1 pulsed in the same cycle its command is accepted -> a second TRACK command follows; track advances by 2 in total.
- KEY_CMD_AUTO_NEXT_EN: with playing=1 and track=3 (NUM_TRACKS=4), pulse song_end -> cmd TRACK with cmd_track=0. With playing=0, pulse song_end -> no cmd_valid within 10 cycles.
